// File: rtl/prog_seq.sv
// Program sequencer: launches a program run, steers the PC start/branch controls,
// latches compare flags and enforces a run-length watchdog.
module prog_seq #(
    parameter int D       = 8,
    parameter int CW      = 16,
    parameter int MAX_CYC = 2**CW-1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    input  logic          br_en,
    input  logic [1:0]    br_cond,
    input  logic [D-1:0]  br_off,
    input  logic          flag_we,
    input  logic          cmp_eq,
    input  logic          cmp_gt,
    output logic          pc_start,
    output logic          reljump_en,
    output logic          E,
    output logic          G,
    output logic [D-1:0]  target,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CYC_SAT = '1;
    localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYC - 1);

    state_t        state_q, state_d;
    logic          flag_e_q, flag_e_d;
    logic          flag_g_q, flag_g_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [CW-1:0] run_cnt;
    logic          in_run;

    // Count of RUN cycles including the current one; the watchdog compares against it
    // so that a run stops once MAX_CYC-1 cycles have been spent.
    assign run_cnt = (cycles_q == CYC_SAT) ? CYC_SAT : cycles_q + CW'(1);
    assign in_run  = (state_q == S_RUN);

    always_comb begin
        state_d   = state_q;
        flag_e_d  = flag_e_q;
        flag_g_d  = flag_g_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_RUN;
                    flag_e_d  = 1'b0;
                    flag_g_d  = 1'b0;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                end
            end
            S_RUN: begin
                cycles_d = run_cnt;
                if (flag_we) begin
                    flag_e_d = cmp_eq;
                    flag_g_d = cmp_gt;
                end
                if (halt) begin
                    state_d = S_DONE;
                end else if (run_cnt == WD_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = in_run;
        done       = (state_q == S_DONE);
        pc_start   = !in_run;
        reljump_en = in_run && br_en && !halt;
        target     = reljump_en ? br_off : '0;
        // Flags come from registers only, so a same-cycle compare cannot steer this branch.
        E          = reljump_en && ((br_cond == 2'b00) || (br_cond[0] && flag_e_q));
        G          = reljump_en && br_cond[1] && flag_g_q;
        timeout    = timeout_q;
        cycles     = cycles_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            flag_e_q  <= 1'b0;
            flag_g_q  <= 1'b0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            flag_e_q  <= flag_e_d;
            flag_g_q  <= flag_g_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

endmodule

// File: tb/tb_prog_seq.sv
// Randomised and directed bench for prog_seq against a cycle-level behavioural model.
module tb_prog_seq;

    localparam int D       = 8;
    localparam int CW      = 8;
    localparam int MAX_CYC = 5;
    localparam int CYC_SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          halt = 1'b0;
    logic          br_en = 1'b0;
    logic [1:0]    br_cond = 2'b00;
    logic [D-1:0]  br_off = '0;
    logic          flag_we = 1'b0;
    logic          cmp_eq = 1'b0;
    logic          cmp_gt = 1'b0;
    logic          pc_start, reljump_en, E, G, busy, done, timeout;
    logic [D-1:0]  target;
    logic [CW-1:0] cycles;

    prog_seq #(.D(D), .CW(CW), .MAX_CYC(MAX_CYC)) dut (
        .clk(clk), .reset(reset), .req(req), .halt(halt), .br_en(br_en),
        .br_cond(br_cond), .br_off(br_off), .flag_we(flag_we), .cmp_eq(cmp_eq),
        .cmp_gt(cmp_gt), .pc_start(pc_start), .reljump_en(reljump_en), .E(E), .G(G),
        .target(target), .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: running/finished flags instead of a state code, plain integer counters.
    bit m_running = 0, m_finished = 0;
    bit m_fe = 0, m_fg = 0, m_to = 0;
    int m_cyc = 0;
    int busy_seen = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit rj, xe, xg;
        rj = m_running && br_en && !halt;
        case (br_cond)
            2'b00: begin xe = 1'b1; xg = 1'b0; end
            2'b01: begin xe = m_fe; xg = 1'b0; end
            2'b10: begin xe = 1'b0; xg = m_fg; end
            default: begin xe = m_fe; xg = m_fg; end
        endcase
        chk("busy",       32'(busy),       32'(m_running));
        chk("done",       32'(done),       32'(m_finished));
        chk("pc_start",   32'(pc_start),   32'(!m_running));
        chk("reljump_en", 32'(reljump_en), 32'(rj));
        chk("E",          32'(E),          32'(rj && xe));
        chk("G",          32'(G),          32'(rj && xg));
        chk("target",     32'(target),     rj ? 32'(br_off) : 32'd0);
        chk("timeout",    32'(timeout),    32'(m_to));
        chk("cycles",     32'(cycles),     32'(m_cyc));
    endtask

    task automatic model_edge();
        int n;
        if (reset) begin
            m_running = 0; m_finished = 0; m_fe = 0; m_fg = 0; m_cyc = 0; m_to = 0;
        end else if (m_running) begin
            n = m_cyc + 1;
            if (flag_we) begin m_fe = cmp_eq; m_fg = cmp_gt; end
            m_cyc = (n > CYC_SAT) ? CYC_SAT : n;
            if (halt) begin
                m_running = 0; m_finished = 1;
            end else if (n == MAX_CYC - 1) begin
                m_running = 0; m_finished = 1; m_to = 1;
            end
        end else if (m_finished) begin
            if (!req) m_finished = 0;
        end else if (req) begin
            m_running = 1; m_fe = 0; m_fg = 0; m_cyc = 0; m_to = 0;
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick(input bit do_cmp);
        #1;
        if (do_cmp) compare_all();
        if (busy === 1'b1) busy_seen++;
        if (done === 1'b1) done_seen++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clr_in();
        reset = 0; req = 0; halt = 0; br_en = 0; br_cond = 2'b00; br_off = '0;
        flag_we = 0; cmp_eq = 0; cmp_gt = 0;
    endtask

    task automatic launch();
        clr_in(); req = 1'b1; tick(1);
        req = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        tick(0);
        clr_in();
        #1;
        chk("rst_pc_start", 32'(pc_start), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_timeout",  32'(timeout),  32'd0);
        chk("rst_cycles",   32'(cycles),   32'd0);
        chk("rst_rj",       32'(reljump_en), 32'd0);
        tick(1);

        // Halt on the 4th RUN cycle.
        busy_seen = 0;
        launch();
        tick(1); tick(1); tick(1);
        halt = 1'b1; tick(1); halt = 1'b0;
        #1;
        chk("s1_busy_cycles", 32'(busy_seen), 32'd4);
        chk("s1_cycles",      32'(cycles),    32'd4);
        chk("s1_done",        32'(done),      32'd1);
        chk("s1_timeout",     32'(timeout),   32'd0);
        tick(1);
        #1;
        chk("s1_idle", 32'(done), 32'd0);

        // Equal flag steering a cond=01 branch, then the same branch with the flag cleared.
        launch();
        flag_we = 1; cmp_eq = 1; tick(1);
        clr_in(); br_en = 1; br_cond = 2'b01; br_off = 8'hFC;
        #1;
        chk("s2_rj",     32'(reljump_en), 32'd1);
        chk("s2_E",      32'(E),          32'd1);
        chk("s2_G",      32'(G),          32'd0);
        chk("s2_target", 32'(target),     32'hFC);
        flag_we = 1; cmp_eq = 0; tick(1);
        flag_we = 0;
        #1;
        chk("s2_E_clr", 32'(E), 32'd0);
        clr_in(); halt = 1; tick(1); halt = 0; tick(1);

        // Same-cycle compare and cond=10 branch sees the old greater flag.
        launch();
        flag_we = 1; cmp_gt = 1; tick(1);
        clr_in(); flag_we = 1; cmp_gt = 0; br_en = 1; br_cond = 2'b10; br_off = 8'h05;
        #1;
        chk("s3_G_old", 32'(G), 32'd1);
        tick(1);
        flag_we = 0;
        #1;
        chk("s3_G_new", 32'(G), 32'd0);
        clr_in(); halt = 1; tick(1); halt = 0; tick(1);

        // Watchdog expiry, then a relaunch clears timeout.
        launch();
        tick(1); tick(1); tick(1); tick(1);
        #1;
        chk("s4_done",    32'(done),    32'd1);
        chk("s4_timeout", 32'(timeout), 32'd1);
        chk("s4_cycles",  32'(cycles),  32'd4);
        tick(1);
        launch();
        #1;
        chk("s4_to_clr", 32'(timeout), 32'd0);
        halt = 1; tick(1); halt = 0; tick(1);

        // Halt beats branch; req held through DONE does not relaunch.
        launch();
        halt = 1; br_en = 1; br_cond = 2'b00; br_off = 8'h11;
        #1;
        chk("s5_rj", 32'(reljump_en), 32'd0);
        tick(1);
        clr_in(); req = 1;
        tick(1); tick(1);
        #1;
        chk("s5_stay_done", 32'(done), 32'd1);
        chk("s5_not_busy",  32'(busy), 32'd0);
        req = 0; tick(1);

        // Reset at RUN cycle 3 aborts without a done pulse.
        done_seen = 0;
        launch();
        tick(1); tick(1);
        reset = 1; tick(1); reset = 0;
        #1;
        chk("s6_busy",     32'(busy),     32'd0);
        chk("s6_pc_start", 32'(pc_start), 32'd1);
        chk("s6_cycles",   32'(cycles),   32'd0);
        tick(1);
        chk("s6_no_done",  32'(done_seen), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            reset   = ($urandom_range(0, 59) == 0);
            req     = ($urandom_range(0, 2) != 0);
            halt    = ($urandom_range(0, 5) == 0);
            br_en   = $urandom_range(0, 1);
            br_cond = 2'($urandom_range(0, 3));
            br_off  = 8'($urandom);
            flag_we = $urandom_range(0, 1);
            cmp_eq  = $urandom_range(0, 1);
            cmp_gt  = $urandom_range(0, 1);
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 Parameter D, default 8, sets the program-counter and branch-offset width.
REQ-002 Parameter CW, default 16, sets the run-cycle counter width.
REQ-003 Parameter MAX_CYC, default 2**CW-1, sets the watchdog limit in RUN cycles.
REQ-004 Port clk  input  1  is the sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  is a synchronous, active-high reset.
REQ-006 Port req  input  1  is the run request (level; sampled in IDLE and DONE).
REQ-007 Port halt  input  1  means the current instruction is halt.
REQ-008 Port br_en  input  1  means the current instruction is a relative branch.
REQ-009 Port br_cond  input  2  selects the condition: 00 always, 01 if flag E, 10 if flag G, 11 if E or G.
REQ-010 Port br_off  input  D  is the relative branch offset (two's complement, passed through).
REQ-011 Port flag_we  input  1  strobes a compare result into the flags.
REQ-012 Port cmp_eq  input  1  is the compare equal result.
REQ-013 Port cmp_gt  input  1  is the compare greater result.
REQ-014 Port pc_start  output  1  drives the PC start (clear to 0).
REQ-015 Port reljump_en  output  1  drives the PC relative-jump enable.
REQ-016 Port E  output  1  drives the PC E-qualified jump input.
REQ-017 Port G  output  1  drives the PC G-qualified jump input.
REQ-018 Port target  output  D  drives the PC jump distance.
REQ-019 Port busy  output  1  is high while in RUN.
REQ-020 Port done  output  1  is high while in DONE.
REQ-021 Port timeout  output  1  is a sticky watchdog-expired flag.
REQ-022 Port cycles  output  CW  is the RUN-cycle count of the current or last run.

Function
REQ-023 The FSM SHALL have states IDLE, RUN and DONE, encoded as registered state.
REQ-024 In IDLE, req=1 SHALL transition to RUN at the next edge, clear flagE/flagG, cycles and timeout, and the PC (held at 0) fetches instruction 0 in the first RUN cycle.
REQ-025 pc_start SHALL be 1 in IDLE and DONE, and 0 in RUN.
REQ-026 reljump_en SHALL be 1 only in RUN with br_en=1 and halt=0; otherwise 0.
REQ-027 target SHALL equal br_off when reljump_en=1, else 0.
REQ-028 When reljump_en=1, outputs SHALL be: cond 00 -> E=1,G=0; 01 -> E=flagE,G=0; 10 -> E=0,G=flagG; 11 -> E=flagE,G=flagG; E=G=0 whenever reljump_en=0.
REQ-029 E and G SHALL be combinational from the registered flags, so a compare written at edge k affects a branch in cycle k+1, not the same cycle.
REQ-030 In RUN, flag_we=1 SHALL load flagE<=cmp_eq and flagG<=cmp_gt; flag_we SHALL be ignored outside RUN.
REQ-031 In RUN, halt=1 SHALL transition to DONE; halt has priority over br_en; a flag_we in the same cycle still updates the flags.
REQ-032 cycles SHALL increment by 1 each RUN cycle, saturating at 2**CW-1, and hold its value in DONE and IDLE.
REQ-033 In RUN, if cycles==MAX_CYC-1 and halt=0, the FSM SHALL go to DONE and set timeout=1; timeout holds until the next launch or reset.
REQ-034 In DONE, done=1 is held until req=0, then the FSM goes to IDLE at the next edge (four-phase handshake; a held-high req does not restart).
REQ-035 req SHALL be ignored in RUN.

Reset
REQ-036 reset=1 SHALL override all inputs: state IDLE, flagE=flagG=0, cycles=0, timeout=0; outputs pc_start=1, reljump_en=0, E=G=0, target=0, busy=0, done=0.
REQ-037 reset asserted mid-RUN SHALL abort the run with no done pulse, and pc_start=1 from the following cycle.

Verification
REQ-038 Scenario: reset, req=1 for 1 cycle, halt at 4th RUN cycle -> busy for 4 cycles, cycles=4, done=1 until req=0, then IDLE, timeout=0.
REQ-039 Scenario: flag_we with cmp_eq=1 at cycle 1, br_en, cond=01, br_off=8'hFC at cycle 2 -> reljump_en=1, E=1, G=0, target=8'hFC; same branch with cmp_eq=0 -> E=0.
REQ-040 Scenario: flag_we and a cond=10 branch in the same cycle -> G reflects the old flagG; the next cycle reflects the new value.
REQ-041 Scenario: MAX_CYC=5, no halt -> DONE after 4 RUN cycles with timeout=1, cycles=4; next launch clears timeout.
REQ-042 Scenario: halt and br_en both 1 -> reljump_en=0 and the FSM enters DONE; req held high through DONE -> stays in DONE with no relaunch.
REQ-043 Scenario: reset at RUN cycle 3 -> next cycle IDLE, pc_start=1, cycles=0, done never asserted.
